// File: rtl/lieat_pipe_skid.sv
// Two-entry elastic pipeline register (main + skid) with registered i_ready
// and synchronous flush; occupancy doubles as the exposed FSM state.
module lieat_pipe_skid #(
  parameter int              DW      = 32,
  parameter logic [DW-1:0]   DEFAULT = {DW{1'b0}}
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic [1:0]    occupancy
);

  // Handshake: a beat transfers on a rising edge where valid & ready are both
  // high; valid never waits on ready, and i_ready is a flop so no ready path
  // runs from the downstream side to the upstream side.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    ONE     = 2'd1,
    FULL    = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          ready_q, ready_d;
  logic          i_fire, o_fire;

  assign i_fire    = i_valid & ready_q & ~flush;
  assign o_valid   = (state_q != EMPTY) & ~flush;
  assign o_fire    = o_valid & o_ready;
  assign i_ready   = ready_q;
  assign o_data    = main_q;
  assign occupancy = state_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (i_fire) begin
          state_d = ONE;
          main_d  = i_data;
        end
      end
      ONE: begin
        if (i_fire && o_fire) begin
          main_d = i_data;
        end else if (i_fire) begin
          state_d = FULL;
          skid_d  = i_data;
        end else if (o_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (o_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Data registers are left alone on flush; they are don't-care once EMPTY.
    if (flush) state_d = EMPTY;
    ready_d = (state_d != FULL);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= DEFAULT;
      skid_q  <= DEFAULT;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: tb/tb_lieat_pipe_skid.sv
// Bench for lieat_pipe_skid: directed scenarios then randomized traffic,
// all checked against a two-slot queue model of the buffer.
module tb_lieat_pipe_skid;

  localparam int            DW      = 32;
  localparam logic [DW-1:0] DEFAULT = {DW{1'b0}};

  logic          clock;
  logic          reset;
  logic          flush;
  logic          i_valid;
  logic          i_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic [1:0]    occupancy;

  int checks = 0;
  int errors = 0;

  // Reference model: accepted beats in order, capacity two.
  logic [DW-1:0] exp_q[$];
  bit            m_ready;
  bit            m_dflt;
  bit            last_taken;

  lieat_pipe_skid #(.DW(DW), .DEFAULT(DEFAULT)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_data    (i_data),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .occupancy (occupancy)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, clock, update model.
  task automatic cyc(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic fl);
    bit exp_valid, in_f, out_f;
    i_valid = iv;
    i_data  = id;
    o_ready = ordy;
    flush   = fl;
    #1;
    exp_valid = (exp_q.size() > 0) && !fl;
    chk("o_valid", {31'd0, o_valid}, {31'd0, exp_valid});
    chk("i_ready", {31'd0, i_ready}, {31'd0, m_ready});
    chk("occupancy", {30'd0, occupancy}, 32'(exp_q.size()));
    if (exp_q.size() > 0)
      chk("o_data", o_data, exp_q[0]);
    else if (m_dflt)
      chk("o_data_default", o_data, DEFAULT);
    in_f       = iv && m_ready && !fl;
    out_f      = exp_valid && ordy;
    last_taken = iv && m_ready;
    @(posedge clock);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (out_f) void'(exp_q.pop_front());
      if (in_f) begin
        exp_q.push_back(id);
        m_dflt = 1'b0;
      end
    end
    m_ready = (exp_q.size() != 2);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_o_valid"}, {31'd0, o_valid}, 32'd0);
    chk({tag, "_i_ready"}, {31'd0, i_ready}, 32'd0);
    chk({tag, "_occupancy"}, {30'd0, occupancy}, 32'd0);
    chk({tag, "_o_data"}, o_data, DEFAULT);
  endtask

  initial begin
    bit            cur_v;
    logic [DW-1:0] cur_d;
    reset   = 1'b0;
    flush   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    o_ready = 1'b0;
    m_ready = 1'b0;
    m_dflt  = 1'b1;
    last_taken = 1'b0;

    // Reset state, then release away from an edge.
    #2;
    check_reset_values("reset");
    @(posedge clock);
    #1;
    reset = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("ready_after_release", {31'd0, i_ready}, 32'd1);

    // Streaming with o_ready high.
    cyc(1'b1, 32'h11, 1'b1, 1'b0);
    chk("stream_first", o_data, 32'h11);
    cyc(1'b1, 32'h22, 1'b1, 1'b0);
    chk("stream_second", o_data, 32'h22);
    cyc(1'b1, 32'h33, 1'b1, 1'b0);
    chk("stream_third", o_data, 32'h33);
    chk("stream_occ", {30'd0, occupancy}, 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Stall from the second beat.
    cyc(1'b1, 32'hA0, 1'b1, 1'b0);
    cyc(1'b1, 32'hA1, 1'b0, 1'b0);
    cyc(1'b1, 32'hA2, 1'b0, 1'b0);
    chk("stall_main", o_data, 32'hA0);
    chk("stall_ready", {31'd0, i_ready}, 32'd0);
    chk("stall_occ", {30'd0, occupancy}, 32'd2);
    cyc(1'b1, 32'hA2, 1'b0, 1'b0);
    cyc(1'b1, 32'hA2, 1'b1, 1'b0);
    chk("resume_data", o_data, 32'hA1);
    chk("resume_ready", {31'd0, i_ready}, 32'd1);
    cyc(1'b1, 32'hA2, 1'b1, 1'b0);
    cyc(1'b1, 32'hA3, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // FULL, then a single-cycle o_ready pulse.
    cyc(1'b1, 32'hB0, 1'b0, 1'b0);
    cyc(1'b1, 32'hB1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("pulse_ready", {31'd0, i_ready}, 32'd1);
    chk("pulse_occ", {30'd0, occupancy}, 32'd1);
    chk("pulse_data", o_data, 32'hB1);

    // Flush while FULL with a beat presented.
    cyc(1'b1, 32'hB2, 1'b0, 1'b0);
    cyc(1'b1, 32'h55, 1'b1, 1'b1);
    chk("flush_occ", {30'd0, occupancy}, 32'd0);
    chk("flush_ready", {31'd0, i_ready}, 32'd1);
    cyc(1'b1, 32'hC0, 1'b1, 1'b0);
    chk("post_flush_data", o_data, 32'hC0);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset with two beats held.
    cyc(1'b1, 32'hD0, 1'b0, 1'b0);
    cyc(1'b1, 32'hD1, 1'b0, 1'b0);
    chk("pre_reset_occ", {30'd0, occupancy}, 32'd2);
    i_valid = 1'b1;
    i_data  = 32'hD2;
    o_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("async_reset");
    exp_q.delete();
    m_ready = 1'b0;
    m_dflt  = 1'b1;
    @(posedge clock);
    #1;
    check_reset_values("held_reset");
    reset = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("ready_after_rerelease", {31'd0, i_ready}, 32'd1);

    // Randomized traffic; upstream holds a beat until it is taken.
    cur_v = 1'b0;
    cur_d = '0;
    for (int n = 0; n < 10000; n++) begin
      if (!cur_v && ($urandom_range(0, 3) != 0)) begin
        cur_v = 1'b1;
        cur_d = $urandom;
      end
      cyc(cur_v, cur_d, ($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0));
      if (last_taken) cur_v = 1'b0;
    end
    for (int n = 0; n < 4; n++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drained_occ", {30'd0, occupancy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lieat_pipe_skid.md
# lieat_pipe_skid

Two-entry elastic pipeline register with a valid/ready handshake on both sides and a synchronous flush. It sits between adjacent pipeline stages of the core, directly upstream of the stage's plain load-enable data flops. It lets the upstream stage keep issuing one beat per cycle while the downstream stage stalls, without a combinational ready path from `o_ready` to `i_ready`.

## Interface
- `DW`, 32, payload width in bits.
- `DEFAULT`, {DW{1'b0}}, reset value of both data registers.

- `clock`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to `clock` externally).
- `flush`  input  1  synchronous pipeline flush; highest priority after reset.
- `i_valid`  input  1  upstream beat valid.
- `i_ready`  output  1  registered; buffer can accept a beat this cycle.
- `i_data`  input  DW  upstream payload.
- `o_valid`  output  1  downstream beat valid.
- `o_ready`  input  1  downstream accepts beat this cycle.
- `o_data`  output  DW  downstream payload, driven directly from the main register.
- `occupancy`  output  2  number of held beats: 0, 1 or 2.

## Operation
- Storage: main register (`main`) and skid register (`skid`), both DW wide.
- Handshake terms:
  - `i_fire = i_valid & i_ready & ~flush`.
  - `o_fire = o_valid & o_ready`.
- State machine, 2-bit encoding, equal to `occupancy`:
  - EMPTY (0):
    - `i_fire` -> ONE, `main <= i_data`.
    - Otherwise stay.
  - ONE (1):
    - `i_fire & o_fire` -> ONE, `main <= i_data`.
    - `i_fire & ~o_fire` -> FULL, `skid <= i_data`.
    - `~i_fire & o_fire` -> EMPTY.
    - Neither -> stay.
  - FULL (2):
    - `o_fire` -> ONE, `main <= skid`.
    - `i_ready` is 0 in FULL, so `i_fire` cannot occur.
- Outputs:
  - `o_valid = (state != EMPTY) & ~flush`.
  - `i_ready` is a flop; its next value is 1 unless the next state is FULL.
- `flush`:
  - Next state is EMPTY.
  - `i_ready` is 1 on the following cycle.
  - Any beat presented by upstream in the flush cycle is dropped; upstream treats it as consumed if `i_ready` was high.
  - `main` and `skid` keep their contents (don't-care once EMPTY).
  - `o_valid` is forced low in the flush cycle, so no downstream handshake completes.
- Ordering: beats leave in exactly the order accepted; no beat is duplicated or lost except by `flush`.
- Illegal state encoding 3: recover to EMPTY on the next edge.

## Timing
- Reset (`reset` low), effective immediately:
  - state EMPTY, `occupancy` 0, `o_valid` 0, `i_ready` 0.
  - `main` and `skid` = `DEFAULT`, so `o_data` = `DEFAULT`.
- First rising edge after `reset` returns high: `i_ready` goes to 1.
- Reset asserted mid-transfer: all held beats are discarded and no handshake completes while `reset` is low.
- Latency: a beat accepted at edge N into EMPTY has `o_valid` high and `o_data` valid after edge N.
- Throughput: 1 beat/cycle sustained while `o_ready` stays high.
- Stall:
  - First cycle of `o_ready` low with a beat held: buffer accepts one more beat into `skid`.
  - `i_ready` drops after that edge.
- Resume from FULL: `o_fire` at edge M moves the state to ONE and sets `i_ready` to 1 after edge M.
  - Upstream can issue again in cycle M+1.
- No combinational path from `o_ready` or `o_valid` to `i_ready`.
- `o_valid` depends combinationally only on state and `flush`.
- `o_data` is stable while `o_valid & ~o_ready`; AXI-style hold rule.

## Test plan
- Reset release, then stream 0x11, 0x22, 0x33 with `o_ready` held 1:
  - `o_data` shows 0x11, 0x22, 0x33 on consecutive cycles, one cycle after each accept.
  - `occupancy` stays at 1.
- Stream 0xA0..0xA3 with `o_ready` low for 3 cycles from the second beat:
  - 0xA0 held in main, 0xA1 in skid, `i_ready` 0, `occupancy` 2.
  - On release, outputs are 0xA0, 0xA1, 0xA2, 0xA3 in order, none lost.
- FULL with `o_ready` pulsed for 1 cycle:
  - Next cycle `i_ready` is 1, `occupancy` 1, `o_data` equals the former skid value.
- `flush` asserted in FULL while `i_valid` is 1 with 0x55:
  - `o_valid` is 0 in the flush cycle.
  - Next cycle: `occupancy` 0, `i_ready` 1, and 0x55 never appears on `o_data`.
- `reset` pulled low asynchronously mid-stream with `occupancy` 2:
  - `o_valid` and `i_ready` drop immediately.
  - `o_data` = `DEFAULT`.
  - `i_ready` returns to 1 one edge after release.
- Random `i_valid`/`o_ready` for 10k cycles against a FIFO scoreboard:
  - No reorder, loss or duplication.
  - `o_data` stable under stall.
  - `i_ready` is 0 only when `occupancy` is 2.
